// File: rtl/vga_timing_ctrl_if.sv
// Raster timing bundle between the VGA timing controller and the pixel source / DAC stage.
interface vga_timing_ctrl_if;
    logic       en;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       line_start;
    logic       frame_start;

    modport master (
        output en,
        input  hsync, vsync, de, pix_x, pix_y, line_start, frame_start
    );

    modport slave (
        input  en,
        output hsync, vsync, de, pix_x, pix_y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: H/V phase FSMs with down-counters drive syncs, de, coordinates and strobes.
// Optional macro VGA_OUT_PIPE_EN delays hsync/vsync/de by one extra register stage.
module vga_timing_ctrl #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_timing_ctrl_if.slave  vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 ||
            H_BP < 1 || V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
            $error("vga_timing_ctrl: illegal timing, totals must be <= 1024 and phases >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYNC, PH_BP} phase_e;

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            PH_ACT:  next_phase = PH_FP;
            PH_FP:   next_phase = PH_SYNC;
            PH_SYNC: next_phase = PH_BP;
            PH_BP:   next_phase = PH_ACT;
            default: next_phase = PH_ACT;
        endcase
    endfunction

    function automatic logic [9:0] h_len_m1(input phase_e p);
        case (p)
            PH_ACT:  h_len_m1 = 10'(H_ACTIVE - 1);
            PH_FP:   h_len_m1 = 10'(H_FP - 1);
            PH_SYNC: h_len_m1 = 10'(H_SYNC - 1);
            PH_BP:   h_len_m1 = 10'(H_BP - 1);
            default: h_len_m1 = 10'(H_ACTIVE - 1);
        endcase
    endfunction

    function automatic logic [9:0] v_len_m1(input phase_e p);
        case (p)
            PH_ACT:  v_len_m1 = 10'(V_ACTIVE - 1);
            PH_FP:   v_len_m1 = 10'(V_FP - 1);
            PH_SYNC: v_len_m1 = 10'(V_SYNC - 1);
            PH_BP:   v_len_m1 = 10'(V_BP - 1);
            default: v_len_m1 = 10'(V_ACTIVE - 1);
        endcase
    endfunction

    phase_e     h_state_r, h_state_s, v_state_r, v_state_s;
    logic [9:0] h_cnt_r, h_cnt_s, v_cnt_r, v_cnt_s;
    logic [9:0] pix_x_r, pix_x_s, pix_y_r, pix_y_s;
    logic       running_r;
    logic       h_last_s, v_last_s;
    logic       hsync_r, vsync_r, de_r, line_start_r, frame_start_r;
    logic       hsync_s, vsync_s, de_s, line_start_s, frame_start_s;

    // Next raster position: idle or first enabled edge loads (0,0); otherwise step both FSMs.
    always_comb begin
        h_state_s = h_state_r;
        h_cnt_s   = h_cnt_r;
        v_state_s = v_state_r;
        v_cnt_s   = v_cnt_r;
        pix_x_s   = pix_x_r;
        pix_y_s   = pix_y_r;
        h_last_s  = (h_state_r == PH_BP) && (h_cnt_r == 10'd0);
        v_last_s  = (v_state_r == PH_BP) && (v_cnt_r == 10'd0);
        if (!vga.en || !running_r) begin
            h_state_s = PH_ACT;
            h_cnt_s   = h_len_m1(PH_ACT);
            v_state_s = PH_ACT;
            v_cnt_s   = v_len_m1(PH_ACT);
            pix_x_s   = 10'd0;
            pix_y_s   = 10'd0;
        end else begin
            if (h_cnt_r == 10'd0) begin
                h_state_s = next_phase(h_state_r);
                h_cnt_s   = h_len_m1(h_state_s);
            end else begin
                h_cnt_s   = h_cnt_r - 10'd1;
            end
            // The vertical axis only advances on the line wrap, keeping vsync line aligned.
            if (h_last_s) begin
                pix_x_s = 10'd0;
                pix_y_s = v_last_s ? 10'd0 : pix_y_r + 10'd1;
                if (v_cnt_r == 10'd0) begin
                    v_state_s = next_phase(v_state_r);
                    v_cnt_s   = v_len_m1(v_state_s);
                end else begin
                    v_cnt_s   = v_cnt_r - 10'd1;
                end
            end else begin
                pix_x_s = pix_x_r + 10'd1;
            end
        end
    end

    // Output decode from the next state so outputs describe the coordinate loaded on the same edge.
    always_comb begin
        hsync_s       = (vga.en && h_state_s == PH_SYNC) ? HS_POL : ~HS_POL;
        vsync_s       = (vga.en && v_state_s == PH_SYNC) ? VS_POL : ~VS_POL;
        de_s          = vga.en && (h_state_s == PH_ACT) && (v_state_s == PH_ACT);
        line_start_s  = vga.en && (pix_x_s == 10'd0);
        frame_start_s = line_start_s && (pix_y_s == 10'd0);
    end

    // State, coordinate and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_r     <= 1'b0;
            h_state_r     <= PH_ACT;
            h_cnt_r       <= h_len_m1(PH_ACT);
            v_state_r     <= PH_ACT;
            v_cnt_r       <= v_len_m1(PH_ACT);
            pix_x_r       <= 10'd0;
            pix_y_r       <= 10'd0;
            hsync_r       <= ~HS_POL;
            vsync_r       <= ~VS_POL;
            de_r          <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            running_r     <= vga.en;
            h_state_r     <= h_state_s;
            h_cnt_r       <= h_cnt_s;
            v_state_r     <= v_state_s;
            v_cnt_r       <= v_cnt_s;
            pix_x_r       <= pix_x_s;
            pix_y_r       <= pix_y_s;
            hsync_r       <= hsync_s;
            vsync_r       <= vsync_s;
            de_r          <= de_s;
            line_start_r  <= line_start_s;
            frame_start_r <= frame_start_s;
        end
    end

`ifdef VGA_OUT_PIPE_EN
    logic hsync_p_r, vsync_p_r, de_p_r;

    // Extra stage for a one-clk-latency pixel source; clears with en low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_p_r <= ~HS_POL;
            vsync_p_r <= ~VS_POL;
            de_p_r    <= 1'b0;
        end else if (!vga.en) begin
            hsync_p_r <= ~HS_POL;
            vsync_p_r <= ~VS_POL;
            de_p_r    <= 1'b0;
        end else begin
            hsync_p_r <= hsync_r;
            vsync_p_r <= vsync_r;
            de_p_r    <= de_r;
        end
    end

    assign vga.hsync = hsync_p_r;
    assign vga.vsync = vsync_p_r;
    assign vga.de    = de_p_r;
`else
    assign vga.hsync = hsync_r;
    assign vga.vsync = vsync_r;
    assign vga.de    = de_r;
`endif

    assign vga.pix_x       = pix_x_r;
    assign vga.pix_y       = pix_y_r;
    assign vga.line_start  = line_start_r;
    assign vga.frame_start = frame_start_r;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench: three timing controllers (default, tiny, inverted-polarity) against
// an arithmetic raster model driven by the count of enabled clocks since the last (re)start.
module tb_vga_timing_ctrl;
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
    } out_t;

    localparam int   HA[3] = '{640, 4, 6};
    localparam int   HF[3] = '{16, 1, 2};
    localparam int   HS[3] = '{96, 2, 3};
    localparam int   HB[3] = '{48, 1, 2};
    localparam int   VA[3] = '{480, 3, 4};
    localparam int   VF[3] = '{10, 1, 2};
    localparam int   VS[3] = '{2, 1, 2};
    localparam int   VB[3] = '{33, 1, 1};
    localparam logic HP[3] = '{1'b0, 1'b0, 1'b1};
    localparam logic VP[3] = '{1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_v[3];
    int   t[3];
    int   tp[3];
    int   n_checks = 0;
    int   n_fail = 0;

    vga_timing_ctrl_if if0 ();
    vga_timing_ctrl_if if1 ();
    vga_timing_ctrl_if if2 ();
    assign if0.en = en_v[0];
    assign if1.en = en_v[1];
    assign if2.en = en_v[2];

    vga_timing_ctrl #(.H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HS[0]), .H_BP(HB[0]),
                      .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_BP(VB[0]),
                      .HS_POL(HP[0]), .VS_POL(VP[0]))
        u_def (.clk(clk), .rst_n(rst_n), .vga(if0.slave));
    vga_timing_ctrl #(.H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
                      .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]),
                      .HS_POL(HP[1]), .VS_POL(VP[1]))
        u_small (.clk(clk), .rst_n(rst_n), .vga(if1.slave));
    vga_timing_ctrl #(.H_ACTIVE(HA[2]), .H_FP(HF[2]), .H_SYNC(HS[2]), .H_BP(HB[2]),
                      .V_ACTIVE(VA[2]), .V_FP(VF[2]), .V_SYNC(VS[2]), .V_BP(VB[2]),
                      .HS_POL(HP[2]), .VS_POL(VP[2]))
        u_pol (.clk(clk), .rst_n(rst_n), .vga(if2.slave));

    always #5 clk = ~clk;

    // Raster seen n enabled clocks after a (re)start; n < 0 means idle/reset.
    function automatic out_t model(input int i, input int n);
        out_t o;
        int ht, vt, x, y;
        ht = HA[i] + HF[i] + HS[i] + HB[i];
        vt = VA[i] + VF[i] + VS[i] + VB[i];
        if (n < 0) begin
            o = '{hs: ~HP[i], vs: ~VP[i], de: 1'b0, ls: 1'b0, fs: 1'b0, x: 10'd0, y: 10'd0};
        end else begin
            x = n % ht;
            y = (n / ht) % vt;
            o.hs = (x >= HA[i] + HF[i] && x < HA[i] + HF[i] + HS[i]) ? HP[i] : ~HP[i];
            o.vs = (y >= VA[i] + VF[i] && y < VA[i] + VF[i] + VS[i]) ? VP[i] : ~VP[i];
            o.de = (x < HA[i]) && (y < VA[i]);
            o.ls = (x == 0);
            o.fs = (x == 0) && (y == 0);
            o.x  = 10'(x);
            o.y  = 10'(y);
        end
        return o;
    endfunction

    function automatic out_t expect_out(input int i);
        out_t e;
        e = model(i, t[i]);
`ifdef VGA_OUT_PIPE_EN
        if (t[i] >= 0) begin
            out_t p;
            p = model(i, tp[i]);
            e.hs = p.hs;
            e.vs = p.vs;
            e.de = p.de;
        end
`endif
        return e;
    endfunction

    function automatic out_t observe(input int i);
        out_t o;
        case (i)
            0: o = '{if0.hsync, if0.vsync, if0.de, if0.line_start, if0.frame_start, if0.pix_x, if0.pix_y};
            1: o = '{if1.hsync, if1.vsync, if1.de, if1.line_start, if1.frame_start, if1.pix_x, if1.pix_y};
            default: o = '{if2.hsync, if2.vsync, if2.de, if2.line_start, if2.frame_start, if2.pix_x, if2.pix_y};
        endcase
        return o;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("hs%b vs%b de%b ls%b fs%b x%0d y%0d", o.hs, o.vs, o.de, o.ls, o.fs, o.x, o.y);
    endfunction

    // Advance one clock, updating the model from the en/rst_n values the DUT saw on that edge.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            tp[i] = t[i];
            t[i]  = (!rst_n || !en_v[i]) ? -1 : t[i] + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en_v[i] = 1'b1;
            t[i] = -1;
            tp[i] = -1;
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (observe(i) !== expect_out(i)) begin
                    n_fail++;
                    $display("FAIL reset inst%0d got %s want %s", i, fmt(observe(i)), fmt(expect_out(i)));
                end
            end
        end
        n_checks++;
        if (if2.hsync !== 1'b0 || if2.vsync !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pol_syncs got hs%b vs%b want hs0 vs0", if2.hsync, if2.vsync);
        end
    endtask

    task automatic test_first_frame();
        int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0;
        #3 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (observe(i).fs !== 1'b1) begin
                n_fail++;
                $display("FAIL first_frame_start inst%0d got %b want 1", i, observe(i).fs);
            end
        end
        for (int c = 0; c <= 1700; c++) begin
            if (c > 0) tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (observe(i) !== expect_out(i)) begin
                    n_fail++;
                    $display("FAIL raster t=%0d inst%0d got %s want %s", t[i], i, fmt(observe(i)), fmt(expect_out(i)));
                end
            end
            if (t[0] < 800 && if0.de === 1'b1) de_cnt++;
            if (t[0] < 800 && if0.hsync === 1'b0) hs_cnt++;
            if (t[1] < 48 && if1.vsync === 1'b0) vs_cnt++;
            if (if1.frame_start === 1'b1) fs_cnt++;
        end
        n_checks += 4;
        if (de_cnt != 640) begin n_fail++; $display("FAIL line0_de_clks got %0d want 640", de_cnt); end
        if (hs_cnt != 96) begin n_fail++; $display("FAIL line0_hsync_clks got %0d want 96", hs_cnt); end
        if (vs_cnt != 8) begin n_fail++; $display("FAIL small_vsync_clks got %0d want 8", vs_cnt); end
        if (fs_cnt != 1700 / 48 + 1) begin
            n_fail++;
            $display("FAIL small_frame_count got %0d want %0d", fs_cnt, 1700 / 48 + 1);
        end
    endtask

    task automatic test_en_drop();
        bit found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (t[1] >= 0 && t[1] % 48 == 2 * 8 + 5) found = 1'b1;
            else tick();
        end
        n_checks++;
        if (!found || if1.pix_x !== 10'd5 || if1.pix_y !== 10'd2) begin
            n_fail++;
            $display("FAIL en_drop_position got x%0d y%0d want x5 y2", if1.pix_x, if1.pix_y);
        end
        en_v[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (observe(1) !== expect_out(1) || if1.de !== 1'b0 || if1.pix_x !== 10'd0) begin
                n_fail++;
                $display("FAIL en_drop_idle got %s want %s", fmt(observe(1)), fmt(expect_out(1)));
            end
        end
        en_v[1] = 1'b1;
        tick();
        n_checks++;
        if (observe(1) !== expect_out(1) || if1.frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL en_restart got %s want %s", fmt(observe(1)), fmt(expect_out(1)));
        end
    endtask

    task automatic test_random_en();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) en_v[i] = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (observe(i) !== expect_out(i)) begin
                    n_fail++;
                    $display("FAIL random_en t=%0d inst%0d got %s want %s", t[i], i, fmt(observe(i)), fmt(expect_out(i)));
                end
            end
        end
        for (int i = 0; i < 3; i++) en_v[i] = 1'b1;
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 37; c++) tick();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            t[i] = -1;
            tp[i] = -1;
            n_checks++;
            if (observe(i) !== expect_out(i)) begin
                n_fail++;
                $display("FAIL async_reset inst%0d got %s want %s", i, fmt(observe(i)), fmt(expect_out(i)));
            end
        end
        tick();
        #2 rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (observe(i) !== expect_out(i)) begin
                    n_fail++;
                    $display("FAIL after_reset t=%0d inst%0d got %s want %s", t[i], i, fmt(observe(i)), fmt(expect_out(i)));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_en_drop();
        test_random_en();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
